// File: rtl/fetch_bundle_queue_pkg.sv
// Shared fetch package: the bundle entry record and fetch-path constants.
// A fetch bundle carries per-lane valid bits, lane packets and 2-bit
// predictor counters. The entry is sized for the fetch configuration below,
// so queue instances use these values for LANES and PKT_W.
package fetch_bundle_queue_pkg;

    localparam int FBQ_CTR_W = 2;
    localparam int FBQ_LANES = 4;
    localparam int FBQ_PKT_W = 64;

    typedef struct packed {
        logic [FBQ_LANES-1:0]           lane_valid;
        logic [FBQ_LANES*FBQ_PKT_W-1:0] pkt;
        logic [FBQ_LANES*FBQ_CTR_W-1:0] ctr;
    } fbqEntry;

endpackage

// File: rtl/fbq_storage.sv
// Bundle entry array for the fetch bundle queue: one registered write port,
// one combinational read port. The payload is never reset; validity is
// tracked by the pointer/count logic in the parent.
module fbq_storage
    import fetch_bundle_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fbqEntry          wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fbqEntry          rd_data
);

    fbqEntry mem [DEPTH];

    // Capture the incoming bundle at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fetch bundle queue: a DEPTH-entry FIFO of multi-lane fetch bundles.
// Bundles with no valid lane are accepted but dropped. Head fields are read
// straight from storage, so a new bundle appears the cycle after its enqueue.
// Optional feature macro FBQ_LANE_GATE_EN: adds laneActive_i, which masks the
// incoming lane-valid bits before storage and before the empty-bundle test.
module fetch_bundle_queue
    import fetch_bundle_queue_pkg::*;
#(
    parameter int LANES = FBQ_LANES,
    parameter int PKT_W = FBQ_PKT_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [LANES-1:0]             enq_lane_valid_i,
    input  logic [LANES*PKT_W-1:0]       enq_pkt_i,
    input  logic [LANES*FBQ_CTR_W-1:0]   enq_ctr_i,
`ifdef FBQ_LANE_GATE_EN
    input  logic [LANES-1:0]             laneActive_i,
`endif
    output logic                         deq_valid_o,
    input  logic                         deq_ready_i,
    output logic [LANES-1:0]             deq_lane_valid_o,
    output logic [LANES*PKT_W-1:0]       deq_pkt_o,
    output logic [LANES*FBQ_CTR_W-1:0]   deq_ctr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         almost_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LANES-1:0] store_mask;
    logic             do_enq;
    logic             do_deq;
    fbqEntry          wr_entry;
    fbqEntry          head;

`ifdef FBQ_LANE_GATE_EN
    assign store_mask = enq_lane_valid_i & laneActive_i;
`else
    assign store_mask = enq_lane_valid_i;
`endif

    assign enq_ready_o   = (count != CNT_W'(DEPTH));
    assign deq_valid_o   = (count != '0);
    assign almost_full_o = (count >= CNT_W'(DEPTH-1));
    assign count_o       = count;

    // An all-zero lane mask still completes the handshake but stores nothing.
    assign do_enq = enq_valid_i && enq_ready_o && (|store_mask);
    assign do_deq = deq_valid_o && deq_ready_i;

    assign wr_entry.lane_valid = store_mask;
    assign wr_entry.pkt        = enq_pkt_i;
    assign wr_entry.ctr        = enq_ctr_i;

    fbq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (do_enq && !flush_i && !reset),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign deq_lane_valid_o = deq_valid_o ? head.lane_valid : '0;
    assign deq_pkt_o        = head.pkt;
    assign deq_ctr_o        = head.ctr;

    // Pointer and occupancy update; reset dominates flush, flush dominates handshakes.
    // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Testbench for fetch_bundle_queue: a directed vector table, a hand-written
// wrap-around ordering sequence, and randomized traffic against a queue model.
module tb_fetch_bundle_queue;

    localparam int LANES = 4;
    localparam int PKT_W = 64;
    localparam int DEPTH = 4;
    localparam int PW    = LANES*PKT_W;
    localparam int CW    = LANES*2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush_i = 1'b0;
    logic            enq_valid_i = 1'b0;
    logic            enq_ready_o;
    logic [LANES-1:0] enq_lane_valid_i = '0;
    logic [PW-1:0]   enq_pkt_i = '0;
    logic [CW-1:0]   enq_ctr_i = '0;
    logic [LANES-1:0] lane_active = '1;
    logic            deq_valid_o;
    logic            deq_ready_i = 1'b0;
    logic [LANES-1:0] deq_lane_valid_o;
    logic [PW-1:0]   deq_pkt_o;
    logic [CW-1:0]   deq_ctr_o;
    logic [2:0]      count_o;
    logic            almost_full_o;

    fetch_bundle_queue #(.LANES(LANES), .PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush_i),
        .enq_valid_i      (enq_valid_i),
        .enq_ready_o      (enq_ready_o),
        .enq_lane_valid_i (enq_lane_valid_i),
        .enq_pkt_i        (enq_pkt_i),
        .enq_ctr_i        (enq_ctr_i),
`ifdef FBQ_LANE_GATE_EN
        .laneActive_i     (lane_active),
`endif
        .deq_valid_o      (deq_valid_o),
        .deq_ready_i      (deq_ready_i),
        .deq_lane_valid_o (deq_lane_valid_o),
        .deq_pkt_o        (deq_pkt_o),
        .deq_ctr_o        (deq_ctr_o),
        .count_o          (count_o),
        .almost_full_o    (almost_full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0] lv;
        logic [PW-1:0]    pkt;
        logic [CW-1:0]    ctr;
    } ent_t;

    ent_t model_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        logic [PW-1:0] p;
        for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    // Compare every observable output with the queue model.
    task automatic check_model();
        int n;
        n = model_q.size();
        check("count", 256'(count_o), 256'(n));
        check("deq_valid", 256'(deq_valid_o), 256'(n != 0));
        check("enq_ready", 256'(enq_ready_o), 256'(n != DEPTH));
        check("almost_full", 256'(almost_full_o), 256'(n >= DEPTH-1));
        if (n != 0) begin
            check("head_lv", 256'(deq_lane_valid_o), 256'(model_q[0].lv));
            check("head_pkt", 256'(deq_pkt_o), 256'(model_q[0].pkt));
            check("head_ctr", 256'(deq_ctr_o), 256'(model_q[0].ctr));
        end else begin
            check("empty_lv", 256'(deq_lane_valid_o), 256'(0));
        end
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, then check.
    task automatic cycle(input logic r, input logic f, input logic ev,
                         input logic [LANES-1:0] lv, input logic [LANES-1:0] la,
                         input logic dr, input logic [PW-1:0] pkt, input logic [CW-1:0] ctr);
        logic [LANES-1:0] m;
        int               n;
        bit               full, deq, enq;
        ent_t             e;
        reset = r; flush_i = f; enq_valid_i = ev; enq_lane_valid_i = lv;
        lane_active = la; deq_ready_i = dr; enq_pkt_i = pkt; enq_ctr_i = ctr;
`ifdef FBQ_LANE_GATE_EN
        m = lv & la;
`else
        m = lv;
`endif
        n = model_q.size();
        if (r || f) begin
            model_q.delete();
        end else begin
            full = (n == DEPTH);
            deq  = (n != 0) && dr;
            enq  = ev && !full && (m != '0);
            if (deq) void'(model_q.pop_front());
            if (enq) begin
                e.lv = m; e.pkt = pkt; e.ctr = ctr;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic             rst, fl, ev;
        logic [LANES-1:0] lv;
        logic [LANES-1:0] la;
        logic             dr;
        int               cnt;
        logic             dv, er, af;
    } vec_t;

`ifdef FBQ_LANE_GATE_EN
    localparam logic [LANES-1:0] DROP_LV = 4'b1100;
    localparam logic [LANES-1:0] DROP_LA = 4'b0011;
`else
    localparam logic [LANES-1:0] DROP_LV = 4'b0000;
    localparam logic [LANES-1:0] DROP_LA = 4'b1111;
`endif

    vec_t tbl[22];

    initial begin
        // rst fl ev lv la dr | cnt dv er af
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'h5, 4'hF, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'hA, 4'hF, 1'b0, 3, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h1, 4'hF, 1'b0, 4, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 4, 1'b1, 1'b0, 1'b1};
        for (int i = 6; i < 14; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 3, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 4'h3, 4'hF, 1'b1, 2, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, DROP_LV, DROP_LA, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 3, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 4'hC, 4'hF, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 4'h6, 4'hF, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].rst, tbl[i].fl, tbl[i].ev, tbl[i].lv, tbl[i].la, tbl[i].dr,
                  rnd_pkt(), CW'($urandom));
            check($sformatf("tbl%0d_count", i), 256'(count_o), 256'(tbl[i].cnt));
            check($sformatf("tbl%0d_dvalid", i), 256'(deq_valid_o), 256'(tbl[i].dv));
            check($sformatf("tbl%0d_eready", i), 256'(enq_ready_o), 256'(tbl[i].er));
            check($sformatf("tbl%0d_afull", i), 256'(almost_full_o), 256'(tbl[i].af));
        end

        // Wrap-around ordering with known packet values: fill with 1..3, then
        // stream 4..9 in while dequeuing; the head always reads k+2.
        cycle(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, '0, '0);
        for (int k = 1; k <= 3; k++)
            cycle(1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, PW'(k), '0);
        check("wrap_head_first", 256'(deq_pkt_o), 256'(1));
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, PW'(k + 4), '0);
            check($sformatf("wrap_head%0d", k), 256'(deq_pkt_o), 256'(k + 2));
            check($sformatf("wrap_count%0d", k), 256'(count_o), 256'(3));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [LANES-1:0] lv;
            lv = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                  1'($urandom), lv, LANES'($urandom | ($urandom_range(0, 1) ? 32'hF : 32'h0)),
                  $urandom_range(0, 2) != 0, rnd_pkt(), CW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_bundle_queue.md
FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

Interface
REQ-001 SHALL have parameter LANES, default 4: fetch lanes per bundle.
REQ-002 SHALL have parameter PKT_W, default 64: per-lane packet width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: bundle entries; a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1 bit: synchronous queue discard.
REQ-007 SHALL have port enq_valid_i, input, 1 bit: upstream bundle valid.
REQ-008 SHALL have port enq_ready_o, output, 1 bit: queue can accept a bundle.
REQ-009 SHALL have port enq_lane_valid_i, input, LANES bits: per-lane valid.
REQ-010 SHALL have port enq_pkt_i, input, LANES*PKT_W bits: lane packets, lane 0 in the LSBs.
REQ-011 SHALL have port enq_ctr_i, input, LANES*2 bits: per-lane 2-bit predictor counters.
REQ-012 SHALL have port deq_valid_o, output, 1 bit: head bundle valid.
REQ-013 SHALL have port deq_ready_i, input, 1 bit: downstream accepts the head.
REQ-014 SHALL have ports deq_lane_valid_o, deq_pkt_o and deq_ctr_o as outputs, widths equal to their enq_* counterparts: the head bundle.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH+1) bits: occupancy.
REQ-016 SHALL have port almost_full_o, output, 1 bit: asserted when count_o >= DEPTH-1.

Function
REQ-017 SHALL enqueue on a clk edge when enq_valid_i && enq_ready_o && |enq_lane_valid_i.
REQ-018 SHALL accept and silently discard a handshaked bundle whose lane-valid mask is all zero; count_o is unchanged.
REQ-019 SHALL drive enq_ready_o = (count_o != DEPTH), with no combinational dependence on deq_ready_i.
REQ-020 SHALL dequeue on a clk edge when deq_valid_o && deq_ready_i.
REQ-021 SHALL drive deq_valid_o = (count_o != 0); the head fields are read combinationally from storage.
REQ-022 SHALL force deq_lane_valid_o to 0 when the queue is empty.
REQ-023 SHALL make an enqueued bundle visible at the outputs no earlier than the cycle after its enqueue edge (no same-cycle bypass).
REQ-024 SHALL leave count_o unchanged on a simultaneous enqueue and dequeue, including at full (no enqueue is possible when full) and at empty (dequeue is not valid when empty).
REQ-025 SHALL wrap the read and write pointers modulo DEPTH; bundle order is strict FIFO across wrap-around.
REQ-026 SHALL zero the pointers and count on the edge where flush_i is high, discarding any enqueue or dequeue in that cycle.
REQ-027 SHALL keep a held head bundle stable while deq_valid_o && !deq_ready_i.

Reset
REQ-028 SHALL, while reset is high, clear the pointers and count at the edge, giving count_o = 0, deq_valid_o = 0, enq_ready_o = 1, almost_full_o = 0 and deq_lane_valid_o = 0.
REQ-029 SHALL give reset priority over flush_i and over all handshakes, including reset asserted mid-operation; storage payload need not be cleared.

Configuration
REQ-030 SHALL, with macro FBQ_LANE_GATE_EN defined, add an input port laneActive_i of LANES bits and store enq_lane_valid_i & laneActive_i; REQ-018 then applies to the masked value.
REQ-031 SHALL, without FBQ_LANE_GATE_EN, omit laneActive_i and store enq_lane_valid_i unmasked.

Structure
REQ-032 SHALL take the fbqEntry typedef (lane valid, packets, counters) and the FBQ_CTR_W=2 constant from the shared fetch package.
REQ-033 SHALL hold the entry array and its write port in one sub-module, fbq_storage; pointer and count logic SHALL stay in the top module.

Verification
REQ-034 SHALL cover: after reset, enqueue 4 bundles with LANES=4 and DEPTH=4, deq_ready_i=0 -> count_o=4, enq_ready_o=0, almost_full_o=1 once count_o reaches 3.
REQ-035 SHALL cover: at full with deq_ready_i=1 and enq_valid_i=1 for 8 cycles -> 4 dequeues in FIFO order, no enqueue while full, then ordering intact across pointer wrap.
REQ-036 SHALL cover: at count_o=2, simultaneous enqueue and dequeue -> count_o stays 2 and the outputs step to the next bundle in order.
REQ-037 SHALL cover: enqueue with enq_lane_valid_i=4'b0000 (with FBQ_LANE_GATE_EN, laneActive_i=4'b0011 and lane valid 4'b1100) -> bundle dropped, count_o unchanged.
REQ-038 SHALL cover: flush_i high at count_o=3 together with an enqueue -> next cycle count_o=0, deq_valid_o=0, deq_lane_valid_o=0.
REQ-039 SHALL cover: reset high during a concurrent flush and enqueue at count_o=2 -> next cycle every output at its REQ-028 value.
